wptr_full: RTL

Write-side pointer and full-flag generator for the dual-clock gray-pointer FIFO; write-domain counterpart of the read-pointer/empty block. It accepts write requests, advances a binary/gray write pointer, drives the memory write address and enable, and compares against the read pointer, already synchronised into the write domain, to produce a registered `full` flag. It also provides a sticky overflow flag and an optional pessimistic fill level with almost-full indication.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/gray2bin.sv | 17 +
 rtl/wptr_full.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared gray-pointer FIFO definitions for the write and read pointer blocks
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int FIFO_PTR_WIDTH = ptr_width(FIFO_ADDR_WIDTH);

    // Generic up to 32 bits; callers zero-extend and truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational gray-to-binary converter (XOR prefix from the MSB down)
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - write pointer, full/overflow flags; fill level and almost_full under WPTR_FULL_LEVEL_EN
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  almost_full
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    // Full when the read pointer equals ours with the top two gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;

    always_comb begin
        wen        = winc & ~full_q;
        wbin_d     = wbin_q + PW'(wen);
        wptr_d     = PW'(bin2gray(32'(wbin_d)));
        full_d     = (wptr_d == (rptr_sync ^ FULL_MASK));
        overflow_d = overflow_q | (winc & full_q);
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign waddr    = wbin_q[ADDR_WIDTH-1:0];
    assign wptr     = wptr_q;
    assign full     = full_q;
    assign overflow = overflow_q;

`ifdef WPTR_FULL_LEVEL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          almost_full_q, almost_full_d;

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_gray2bin (
        .gray (rptr_sync),
        .bin  (rbin_s)
    );

    // Pessimistic: the synchronised read pointer lags, so this never under-reports.
    always_comb begin
        wlevel_d      = wbin_d - rbin_s;
        almost_full_d = (wlevel_d >= AF_THRESH);
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            wlevel_q      <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;
`else
    logic [31:0] unused_af_level;
    assign unused_af_level = AF_LEVEL;

    assign wlevel      = '0;
    assign almost_full = 1'b0;
`endif

endmodule
